// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor sharing one full-adder cell over WIDTH cycles
//
// Ports:
//   clk      - clock; all state updates occur on its rising edge
//   rst_n    - synchronous active-low reset
//   start    - request to begin an operation (sampled only in IDLE)
//   op       - 0 = add (a+b), 1 = subtract (a+~b+1)
//   a, b     - WIDTH-bit operands, captured on the acceptance edge
//   busy     - high while the operation runs
//   done     - one-cycle pulse when result/carryOut/overflow are valid
//   result   - WIDTH-bit sum/difference, assembled LSB first
//   carryOut - carry out of the MSB
//   overflow - signed overflow flag
//
// Configuration:
//   SERIAL_ADD_SUB_OVERFLOW_EN - when defined, keeps the MSB carry-in register and
//                                drives overflow; otherwise overflow is tied to 0.
module serial_add_sub #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [CW-1:0]    count_q;
    logic             carry_q, busy_q, done_q, carry_out_q;
    logic             sum_d, carry_d, last_d;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic             c_msb_q;
`endif
    // The single shared full-adder cell
    always_comb begin
        sum_d   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_d  = count_q == CW'(WIDTH - 1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            c_msb_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b with carry-in 1
                        state_q <= RUN;
                        a_q     <= a;
                        b_q     <= op ? ~b : b;
                        carry_q <= op;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    result_q <= {sum_d, result_q[WIDTH-1:1]};
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= carry_d;
                    count_q  <= count_q + CW'(1);
                    if (last_d) begin
                        // carry_q here is the carry into the MSB
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        carry_out_q <= carry_d;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
                        c_msb_q     <= carry_q;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryOut = carry_out_q;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    assign overflow = c_msb_q ^ carry_out_q;
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub
module tb_serial_add_sub;
    localparam int W = 5;
    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst_n, start, op;
    logic [W-1:0] a, b;
    logic         busy, done, carryOut, overflow;
    logic [W-1:0] result;
    exp_t         sb[$];
    exp_t         m;
    int           n_checks = 0;
    int           n_pass = 0;
    int           done_cnt = 0;
    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carryOut(carryOut), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W-1:0] yy;
        logic [W:0]   s;
        yy = o ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o};
        e.r = s[W-1:0];
        e.c = s[W];
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        e.v = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
`else
        e.v = 1'b0;
`endif
        return e;
    endfunction
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                m = sb.pop_front();
                check("result", result, m.r);
                check("carry_out", carryOut, m.c);
                check("overflow", overflow, m.v);
            end
        end
    end
    task automatic run(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit noisy);
        exp_t e;
        int   w;
        int   busy_n;
        e = model(o, x, y);
        w = 0;
        while ((busy || done) && w < 40) begin
            @(negedge clk);
            w++;
        end
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = noisy;
        w = 0;
        busy_n = 0;
        while (!done && w < 40) begin
            if (noisy) begin
                op = 1'($urandom);
                a  = W'($urandom);
                b  = W'($urandom);
            end
            busy_n += busy ? 1 : 0;
            w++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_cycles", busy_n, W);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("hold_result", result, e.r);
        check("hold_carry", carryOut, e.c);
    endtask
    initial begin
        int snap;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carryOut, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 5'b00101, 5'b00011, 1'b0);
        run(1'b1, 5'b00011, 5'b00101, 1'b0);
        run(1'b0, 5'b01111, 5'b00001, 1'b0);
        run(1'b1, 5'b00101, 5'b00011, 1'b1);
        run(1'b1, 5'b01001, 5'b00000, 1'b0);
        run(1'b0, 5'b11111, 5'b11111, 1'b0);
        run(1'b1, 5'b00000, 5'b00001, 1'b0);
        run(1'b1, 5'b10000, 5'b00001, 1'b0);
        run(1'b1, 5'b00101, 5'b00011, 1'b0);
        op = 1'b0; a = 5'b01111; b = 5'b00001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_running", busy, 1);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carryOut, 0);
        check("abort_overflow", overflow, 0);
        rst_n = 1'b1; start = 1'b0;
        snap = done_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - snap, 0);
        check("abort_idle", busy, 0);
        for (int i = 0; i < 20; i++) run(1'($urandom), W'($urandom), W'($urandom), 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the operand and result width in bits (legal range 2..16).
REQ-002 Port clk SHALL be an input of width 1: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n SHALL be an input of width 1: reset, synchronous and active-low.
REQ-004 Port start SHALL be an input of width 1: request to begin an operation.
REQ-005 Port op SHALL be an input of width 1: 0 = add (a+b), 1 = subtract (a+~b+1, two's complement of b).
REQ-006 Port a SHALL be an input of width WIDTH: first operand.
REQ-007 Port b SHALL be an input of width WIDTH: second operand.
REQ-008 Port busy SHALL be an output of width 1: high while in RUN.
REQ-009 Port done SHALL be an output of width 1: one-cycle pulse when the result is valid.
REQ-010 Port result SHALL be an output of width WIDTH: sum/difference, LSB first assembled.
REQ-011 Port carryOut SHALL be an output of width 1: carry out of the MSB.
REQ-012 Port overflow SHALL be an output of width 1: signed overflow flag.

Function
REQ-013 The block SHALL use exactly one 1-bit full-adder cell (sum = x^y^c, carry = majority) time-shared over WIDTH cycles.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, a rising edge with start=1 SHALL load aReg=a, bReg=(op ? ~b : b), carry=op, count=0, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL hold all registers.
REQ-017 Each RUN edge SHALL compute the sum bit from aReg[0], bReg[0] and carry, shift it into result at the MSB (result shifts right), shift aReg and bReg right, update carry, and increment count.
REQ-018 On the RUN edge where count reaches WIDTH-1, the block SHALL record the carry-in to the MSB (cMsb), then enter DONE.
REQ-019 In DONE, the block SHALL assert done=1 for exactly one cycle, present carryOut=carry and overflow=cMsb^carry, and return to IDLE on the next edge unconditionally.
REQ-020 Latency SHALL be fixed: done is high in the cycle after the WIDTH-th edge following acceptance.
REQ-021 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in RUN and DONE; changes to a, b and op after acceptance SHALL NOT affect the operation.
REQ-023 result, carryOut and overflow SHALL hold their values from DONE until the next acceptance edge.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; subtracting 0 (op=1, b=0) SHALL yield result=a and carryOut=1.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, result, carryOut, overflow, carry, count, aReg and bReg to 0, regardless of state.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; start sampled in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-027 When macro SERIAL_ADD_SUB_OVERFLOW_EN is defined, the block SHALL include the cMsb register and drive overflow per REQ-019.
REQ-028 When SERIAL_ADD_SUB_OVERFLOW_EN is undefined, the block SHALL omit cMsb and tie overflow to constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-029 Scenario: op=0, a=00101, b=00011 -> done after 5 edges; result=01000, carryOut=0, overflow=0.
REQ-030 Scenario: op=1, a=00101, b=00011 -> result=00010, carryOut=1, overflow=0.
REQ-031 Scenario: op=1, a=00011, b=00101 -> result=11110, carryOut=0, overflow=0.
REQ-032 Scenario: op=0, a=01111, b=00001 -> result=10000, carryOut=0, overflow=1 (0 with macro undefined).
REQ-033 Scenario: start pulsed again with new operands during RUN -> ignored; the original result is returned, and busy stays high for exactly 5 cycles.
REQ-034 Scenario: rst_n=0 on the third RUN cycle -> next cycle state is IDLE, busy=0, result=00000, and no done pulse occurs.
